// File: rtl/ysyx_23060136_icache_pkg.sv
// ysyx_23060136_icache_pkg: shared widths, NOP encoding, FSM state codes and beat lane select
package ysyx_23060136_icache_pkg;
  localparam int BITS_W = 64;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOOKUP = 3'd1;
  localparam logic [2:0] S_MREQ   = 3'd2;
  localparam logic [2:0] S_MWAIT  = 3'd3;
  localparam logic [2:0] S_RESP   = 3'd4;
  function automatic logic [31:0] lane_sel(input logic [63:0] beat, input logic hi);
    return hi ? beat[63:32] : beat[31:0];
  endfunction
endpackage

// File: rtl/ysyx_23060136_icache_array.sv
// ysyx_23060136_icache_array: direct-mapped valid/tag/data storage with combinational read, one write port and flush-all
module ysyx_23060136_icache_array #(
  parameter int ENTRIES = 16,
  parameter int IDX_W = $clog2(ENTRIES),
  parameter int TAG_W = 30 - IDX_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             we,
  input  logic [IDX_W-1:0] idx,
  input  logic [TAG_W-1:0] tag,
  input  logic [31:0]      wdata,
  output logic             hit,
  output logic [31:0]      rdata
);
  logic [ENTRIES-1:0] valid_q, valid_d;
  logic [TAG_W-1:0]   tag_q [ENTRIES];
  logic [TAG_W-1:0]   tag_d [ENTRIES];
  logic [31:0]        data_q [ENTRIES];
  logic [31:0]        data_d [ENTRIES];
  assign hit   = valid_q[idx] & (tag_q[idx] == tag);
  assign rdata = data_q[idx];
  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    data_d  = data_q;
    if (we) begin
      valid_d[idx] = 1'b1;
      tag_d[idx]   = tag;
      data_d[idx]  = wdata;
    end
    if (flush) valid_d = '0;
  end
  always_ff @(posedge clk) begin
    valid_q <= rst ? '0 : valid_d;
    tag_q   <= tag_d;
    data_q  <= data_d;
  end
endmodule

// File: rtl/ysyx_23060136_icache.sv
// ysyx_23060136_icache: direct-mapped one-word-per-line instruction cache between IFU and arbiter
module ysyx_23060136_icache
  import ysyx_23060136_icache_pkg::*;
#(
  parameter int ENTRIES = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [BITS_W-1:0] IFU_pc,
  input  logic              IFU_pc_valid,
  output logic              IFU_pc_ready,
  output logic [31:0]       IFU_inst,
  output logic              IFU_inst_valid,
  input  logic              IFU_inst_ready,
  output logic              IFU_error,
  input  logic              IFU_fence_i,
  output logic [BITS_W-1:0] ARB_pc,
  output logic              ARB_pc_valid,
  input  logic              ARB_pc_ready,
  input  logic [BITS_W-1:0] ARB_inst,
  input  logic              ARB_inst_valid,
  output logic              ARB_inst_ready,
  input  logic              ARB_error,
  output logic [63:0]       hit_cnt,
  output logic [63:0]       miss_cnt
);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = 30 - IDX_W;
  logic [2:0]        state_q, state_d;
  logic [BITS_W-1:0] pc_q, pc_d;
  logic [31:0]       inst_q, inst_d;
  logic              err_q, err_d;
  logic              flush_pend_q, flush_pend_d;
  logic [63:0]       hit_cnt_q, hit_cnt_d;
  logic [63:0]       miss_cnt_q, miss_cnt_d;
  logic              hit, install;
  logic [31:0]       rdata, word;
  assign word           = lane_sel(ARB_inst, pc_q[2]);
  assign install        = (state_q == S_MWAIT) & ARB_inst_valid & ~ARB_error & ~flush_pend_q;
  assign IFU_pc_ready   = state_q == S_IDLE;
  assign IFU_inst_valid = state_q == S_RESP;
  assign IFU_inst       = inst_q;
  assign IFU_error      = err_q;
  assign ARB_pc         = pc_q;
  assign ARB_pc_valid   = state_q == S_MREQ;
  assign ARB_inst_ready = state_q == S_MWAIT;
  assign hit_cnt        = hit_cnt_q;
  assign miss_cnt       = miss_cnt_q;
  ysyx_23060136_icache_array #(.ENTRIES(ENTRIES)) u_array (
    .clk   (clk),
    .rst   (rst),
    .flush (IFU_fence_i),
    .we    (install),
    .idx   (pc_q[IDX_W+1:2]),
    .tag   (pc_q[31:IDX_W+2]),
    .wdata (word),
    .hit   (hit),
    .rdata (rdata)
  );
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    inst_d     = inst_q;
    err_d      = err_q;
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    case (state_q)
      S_IDLE: begin
        state_d = IFU_pc_valid ? S_LOOKUP : S_IDLE;
        pc_d    = IFU_pc_valid ? IFU_pc : pc_q;
      end
      S_LOOKUP: begin
        state_d    = hit ? S_RESP : S_MREQ;
        inst_d     = hit ? rdata : inst_q;
        err_d      = hit ? 1'b0 : err_q;
        hit_cnt_d  = hit_cnt_q + {63'd0, hit};
        miss_cnt_d = miss_cnt_q + {63'd0, ~hit};
      end
      S_MREQ: state_d = ARB_pc_ready ? S_MWAIT : S_MREQ;
      S_MWAIT: begin
        state_d = ARB_inst_valid ? S_RESP : S_MWAIT;
        inst_d  = ARB_inst_valid ? word : inst_q;
        err_d   = ARB_inst_valid ? ARB_error : err_q;
      end
      S_RESP: state_d = IFU_inst_ready ? S_IDLE : S_RESP;
      default: state_d = S_IDLE;
    endcase
    flush_pend_d = (state_d == S_IDLE) ? 1'b0 :
                   flush_pend_q | (IFU_fence_i & ((state_q == S_MREQ) | (state_q == S_MWAIT)));
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      pc_q         <= '0;
      inst_q       <= NOP;
      err_q        <= 1'b0;
      flush_pend_q <= 1'b0;
      hit_cnt_q    <= '0;
      miss_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      inst_q       <= inst_d;
      err_q        <= err_d;
      flush_pend_q <= flush_pend_d;
      hit_cnt_q    <= hit_cnt_d;
      miss_cnt_q   <= miss_cnt_d;
    end
  end
endmodule

// File: tb/tb_ysyx_23060136_icache.sv
// tb_ysyx_23060136_icache: table-driven and randomized checks against a word-address cache model
module tb_ysyx_23060136_icache;
  typedef struct {
    logic [63:0] pc;
    logic [63:0] beat;
    bit          err;
    int          fence_at;
    int          hold;
    logic [31:0] inst;
    bit          ierr;
    bit          hit;
  } vec_t;
  logic        clk = 0, rst = 1;
  logic [63:0] IFU_pc = '0;
  logic        IFU_pc_valid = 0, IFU_pc_ready;
  logic [31:0] IFU_inst;
  logic        IFU_inst_valid, IFU_inst_ready = 0, IFU_error, IFU_fence_i = 0;
  logic [63:0] ARB_pc;
  logic        ARB_pc_valid, ARB_pc_ready = 0;
  logic [63:0] ARB_inst = '0;
  logic        ARB_inst_valid = 0, ARB_inst_ready, ARB_error = 0;
  logic [63:0] hit_cnt, miss_cnt;
  int checks = 0, errors = 0;
  longint unsigned e_hit = 0, e_miss = 0;
  bit          m_v [16];
  logic [29:0] m_a [16];
  logic [31:0] m_d [16];
  vec_t tbl [14];
  always #5 clk = ~clk;
  ysyx_23060136_icache dut (
    .clk(clk), .rst(rst),
    .IFU_pc(IFU_pc), .IFU_pc_valid(IFU_pc_valid), .IFU_pc_ready(IFU_pc_ready),
    .IFU_inst(IFU_inst), .IFU_inst_valid(IFU_inst_valid), .IFU_inst_ready(IFU_inst_ready),
    .IFU_error(IFU_error), .IFU_fence_i(IFU_fence_i),
    .ARB_pc(ARB_pc), .ARB_pc_valid(ARB_pc_valid), .ARB_pc_ready(ARB_pc_ready),
    .ARB_inst(ARB_inst), .ARB_inst_valid(ARB_inst_valid), .ARB_inst_ready(ARB_inst_ready),
    .ARB_error(ARB_error), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );
  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask
  function automatic bit m_hit(input logic [63:0] pc);
    return m_v[pc[5:2]] && m_a[pc[5:2]] == pc[31:2];
  endfunction
  task automatic m_update(input logic [63:0] pc, input logic [63:0] beat, input bit hit, input bit err, input int fa);
    int i;
    i = int'(pc[5:2]);
    if (hit) e_hit++; else e_miss++;
    if (fa == 1 || (fa == 2 && !hit)) foreach (m_v[k]) m_v[k] = 0;
    if (!hit && !err && fa != 2) begin
      m_v[i] = 1;
      m_a[i] = pc[31:2];
      m_d[i] = pc[2] ? beat[63:32] : beat[31:0];
    end
  endtask
  task automatic fetch(input logic [63:0] pc, input logic [63:0] beat, input bit err, input int fence_at,
                       input int hold, input int lat, output logic [31:0] inst, output bit ierr, output int nreq);
    int cyc, rw, bw;
    bit done, fenced;
    cyc = 0; rw = 0; bw = 0; done = 0; fenced = 0; nreq = 0;
    @(negedge clk);
    chk("pc_ready_idle", IFU_pc_ready, 1);
    IFU_pc = pc;
    IFU_pc_valid = 1;
    while (!done && cyc < 100) begin
      @(negedge clk);
      cyc++;
      IFU_pc_valid = 0; IFU_fence_i = 0; ARB_pc_ready = 0; ARB_inst_valid = 0;
      if (IFU_inst_valid) done = 1;
      else begin
        if (IFU_pc_ready) chk("pc_ready_busy", IFU_pc_ready, 0);
        if (cyc == 1 && fence_at == 1) begin IFU_fence_i = 1; fenced = 1; end
        if (ARB_pc_valid) begin
          chk("arb_pc", ARB_pc, pc);
          if (rw++ >= lat) begin ARB_pc_ready = 1; nreq++; end
        end
        if (ARB_inst_ready) begin
          if (fence_at == 2 && !fenced) begin IFU_fence_i = 1; fenced = 1; end
          if (bw++ >= lat) begin ARB_inst = beat; ARB_error = err; ARB_inst_valid = 1; end
        end
      end
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL timeout pc=%h no IFU_inst_valid within %0d cycles", pc, cyc);
    end
    inst = IFU_inst;
    ierr = IFU_error;
    if (nreq == 0) chk("hit_latency", 64'(cyc), 2);
    repeat (hold) begin
      @(negedge clk);
      chk("hold_valid", IFU_inst_valid, 1);
      chk("hold_inst", IFU_inst, inst);
      chk("hold_err", IFU_error, ierr);
      chk("hold_pc_ready", IFU_pc_ready, 0);
    end
    IFU_inst_ready = 1;
    @(negedge clk);
    IFU_inst_ready = 0;
    chk("resp_done", IFU_inst_valid, 0);
  endtask
  task automatic run(input logic [63:0] pc, input logic [63:0] beat, input bit err, input int fa, input int hold,
                     input int lat, input logic [31:0] x_inst, input bit x_err, input bit x_hit);
    logic [31:0] inst;
    bit ierr;
    int nreq;
    fetch(pc, beat, err, fa, hold, lat, inst, ierr, nreq);
    chk("inst", inst, x_inst);
    chk("ifu_error", ierr, x_err);
    chk("arb_reqs", 64'(nreq), x_hit ? 64'd0 : 64'd1);
    m_update(pc, beat, x_hit, err, fa);
    chk("hit_cnt", hit_cnt, e_hit);
    chk("miss_cnt", miss_cnt, e_miss);
  endtask
  initial begin
    logic [63:0] pc, beat;
    logic [31:0] xi;
    bit h, er;
    int fa;
    tbl[0]  = '{64'h8000_0000, 64'h0000_0013_0000_0297, 0, 0, 0, 32'h0000_0297, 0, 0};
    tbl[1]  = '{64'h8000_0000, 64'h0,                   0, 0, 0, 32'h0000_0297, 0, 1};
    tbl[2]  = '{64'h8000_0004, 64'h1111_1111_2222_2222, 0, 0, 0, 32'h1111_1111, 0, 0};
    tbl[3]  = '{64'h8000_0044, 64'h3333_3333_4444_4444, 0, 0, 0, 32'h3333_3333, 0, 0};
    tbl[4]  = '{64'h8000_0004, 64'h5555_5555_6666_6666, 0, 0, 0, 32'h5555_5555, 0, 0};
    tbl[5]  = '{64'h8000_0044, 64'h7777_7777_8888_8888, 0, 0, 0, 32'h7777_7777, 0, 0};
    tbl[6]  = '{64'h8000_0008, 64'haaaa_aaaa_bbbb_bbbb, 0, 2, 0, 32'hbbbb_bbbb, 0, 0};
    tbl[7]  = '{64'h8000_0008, 64'hcccc_cccc_dddd_dddd, 0, 0, 0, 32'hdddd_dddd, 0, 0};
    tbl[8]  = '{64'h8000_0008, 64'h0,                   0, 1, 0, 32'hdddd_dddd, 0, 1};
    tbl[9]  = '{64'h8000_0008, 64'heeee_eeee_ffff_ffff, 0, 0, 0, 32'hffff_ffff, 0, 0};
    tbl[10] = '{64'h8000_0010, 64'h1234_5678_9abc_def0, 1, 0, 0, 32'h9abc_def0, 1, 0};
    tbl[11] = '{64'h8000_0010, 64'h0fed_cba9_8765_4321, 0, 0, 0, 32'h8765_4321, 0, 0};
    tbl[12] = '{64'h8000_0010, 64'h0,                   0, 0, 5, 32'h8765_4321, 0, 1};
    tbl[13] = '{64'h8000_0014, 64'h0a0a_0a0a_0b0b_0b0b, 0, 0, 5, 32'h0a0a_0a0a, 0, 0};
    repeat (2) @(negedge clk);
    chk("rst_pc_ready", IFU_pc_ready, 1);
    chk("rst_inst", IFU_inst, 32'h0000_0013);
    chk("rst_inst_valid", IFU_inst_valid, 0);
    chk("rst_error", IFU_error, 0);
    chk("rst_arb_pc_valid", ARB_pc_valid, 0);
    chk("rst_arb_inst_ready", ARB_inst_ready, 0);
    chk("rst_hit_cnt", hit_cnt, 0);
    chk("rst_miss_cnt", miss_cnt, 0);
    rst = 0;
    foreach (tbl[i])
      run(tbl[i].pc, tbl[i].beat, tbl[i].err, tbl[i].fence_at, tbl[i].hold, 1, tbl[i].inst, tbl[i].ierr, tbl[i].hit);
    for (int n = 0; n < 200; n++) begin
      pc   = 64'h8000_0000 | 64'($urandom_range(0, 31) << 2) | 64'($urandom_range(0, 3));
      beat = {$urandom, $urandom};
      er   = $urandom_range(0, 7) == 0;
      fa   = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 2)) : 0;
      h    = m_hit(pc);
      xi   = h ? m_d[pc[5:2]] : (pc[2] ? beat[63:32] : beat[31:0]);
      run(pc, beat, er, fa, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), xi, h ? 1'b0 : er, h);
    end
    @(negedge clk);
    IFU_pc = 64'h9000_0000;
    IFU_pc_valid = 1;
    @(negedge clk);
    IFU_pc_valid = 0;
    @(negedge clk);
    chk("mid_mreq", ARB_pc_valid, 1);
    ARB_pc_ready = 1;
    @(negedge clk);
    ARB_pc_ready = 0;
    chk("mid_mwait", ARB_inst_ready, 1);
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("mid_rst_pc_ready", IFU_pc_ready, 1);
    chk("mid_rst_inst", IFU_inst, 32'h0000_0013);
    chk("mid_rst_error", IFU_error, 0);
    chk("mid_rst_hit_cnt", hit_cnt, 0);
    chk("mid_rst_miss_cnt", miss_cnt, 0);
    ARB_inst = 64'hdead_beef_dead_beef;
    ARB_inst_valid = 1;
    repeat (2) begin
      chk("mid_rst_arb_inst_ready", ARB_inst_ready, 0);
      chk("mid_rst_inst_valid", IFU_inst_valid, 0);
      @(negedge clk);
    end
    ARB_inst_valid = 0;
    foreach (m_v[k]) m_v[k] = 0;
    e_hit = 0;
    e_miss = 0;
    run(64'h8000_0000, 64'h0000_0013_0000_0297, 0, 0, 0, 0, 32'h0000_0297, 0, 0);
    run(64'h8000_0000, 64'h0, 0, 0, 0, 0, 32'h0000_0297, 0, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
